// File: rtl/serial_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// start-glitch rejection and a one-entry valid/ready output buffer.
module serial_rx #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 frame_err_out,
   output logic                 overrun_out,
   output logic                 busy_out
);

   localparam int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] T_S0     = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] T_S1     = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] T_DEC    = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t               state, state_next;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [DIV_W-1:0]     div_cnt;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 smp0, smp1;
   logic [DATA_BITS-1:0] shreg;
   logic                 fall, tick, dec, bit_end, maj;
   logic                 deliver, ferr;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign fall    = rx_prev & ~rx_s2;
   assign tick    = (div_cnt == DIV_LAST);
   assign dec     = tick & (tick_cnt == T_DEC);
   assign bit_end = tick & (tick_cnt == T_LAST);
   // third vote is the live synced sample on the decision tick
   assign maj     = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);

   // Timing counters sit at zero in IDLE, so they restart on the start edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         smp0     <= 1'b1;
         smp1     <= 1'b1;
         shreg    <= '0;
      end else if (state == S_IDLE) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == T_S0) smp0 <= rx_s2;
            if (tick_cnt == T_S1) smp1 <= rx_s2;
         end
         if (dec && state == S_DATA) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (fall) state_next = S_START;
         S_START: begin
            if (dec && maj)   state_next = S_IDLE;
            else if (bit_end) state_next = S_DATA;
         end
         S_DATA:  if (bit_end && bit_cnt == BIT_LAST) state_next = S_STOP;
         S_STOP:  if (dec) state_next = maj ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s2) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      deliver = (state == S_STOP) & dec & maj;
      ferr    = (state == S_STOP) & dec & ~maj;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         data_out      <= '0;
         valid_out     <= 1'b0;
         frame_err_out <= 1'b0;
         overrun_out   <= 1'b0;
         busy_out      <= 1'b0;
      end else begin
         frame_err_out <= ferr;
         overrun_out   <= 1'b0;
         busy_out      <= (state_next != S_IDLE);
         if (deliver) begin
            if (!valid_out || ready_in) begin
               data_out  <= shreg;
               valid_out <= 1'b1;
            end else begin
               overrun_out <= 1'b1;
            end
         end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// Directed and randomised frame stimulus for serial_rx, checked against a
// queue of bytes that a correct receiver must hand over.
`timescale 1ns/1ps
module tb_serial_rx;

   localparam int unsigned CLK_HZ  = 100_000_000;
   localparam int unsigned BAUD    = 781_250;
   localparam int unsigned OS      = 16;
   localparam int unsigned DB      = 8;
   localparam int          BIT_NS  = 1280;
   localparam int          FAST_NS = 1243;
   localparam int          SLOW_NS = 1320;

   logic          clk_in   = 1'b0;
   logic          rst_in   = 1'b0;
   logic          rx_in    = 1'b1;
   logic          ready_in = 1'b1;
   logic [DB-1:0] data_out;
   logic          valid_out, frame_err_out, overrun_out, busy_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] hs_q[$];
   int ferr_cnt = 0;
   int ovr_cnt  = 0;
   int busy_cnt = 0;

   serial_rx #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
      .frame_err_out(frame_err_out), .overrun_out(overrun_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (rst_in) begin
         if (valid_out && ready_in) hs_q.push_back(data_out);
         if (frame_err_out) ferr_cnt++;
         if (overrun_out)   ovr_cnt++;
         if (busy_out)      busy_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the line at the stop level; callers restore idle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
      rx_in = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         #(bit_ns);
      end
      rx_in = stop;
      #(bit_ns);
   endtask

   task automatic idle(input int nbits);
      rx_in = 1'b1;
      #(nbits * BIT_NS);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  32'(data_out), 32'h0);
      check({tag, "_valid"}, 32'(valid_out), 32'h0);
      check({tag, "_ferr"},  32'(frame_err_out), 32'h0);
      check({tag, "_ovr"},   32'(overrun_out), 32'h0);
      check({tag, "_busy"},  32'(busy_out), 32'h0);
   endtask

   initial begin
      int base, f0, o0, b0;
      int rate;
      int rates[3];
      logic [7:0] exp_q[$];
      logic [7:0] partial;
      logic [7:0] rb;

      #33;
      check_reset_outputs("rst0");
      rst_in = 1'b1;
      idle(2);

      // 1: single 0x55
      base = hs_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h55, 1'b1, BIT_NS);
      idle(1);
      check("t1_count", 32'(hs_q.size() - base), 32'd1);
      check("t1_byte",  32'(hs_q[base]), 32'h55);
      check("t1_ferr",  32'(ferr_cnt - f0), 32'd0);
      check("t1_ovr",   32'(ovr_cnt - o0), 32'd0);
      check("t1_valid", 32'(valid_out), 32'h0);

      // 2: back-to-back frames, no gap
      base = hs_q.size();
      send_frame(8'hA3, 1'b1, BIT_NS);
      send_frame(8'h0F, 1'b1, BIT_NS);
      idle(1);
      check("t2_count", 32'(hs_q.size() - base), 32'd2);
      check("t2_first", 32'(hs_q[base]), 32'hA3);
      check("t2_second", 32'(hs_q[base+1]), 32'h0F);

      // 3: two-tick low glitch
      base = hs_q.size(); b0 = busy_cnt;
      rx_in = 1'b0;
      #160;
      idle(2);
      check("t3_busy_rose", 32'(busy_cnt > b0), 32'd1);
      check("t3_busy_fell", 32'(busy_out), 32'h0);
      check("t3_no_data",   32'(hs_q.size() - base), 32'd0);
      check("t3_valid",     32'(valid_out), 32'h0);

      // 4: framing error, break, then recovery
      base = hs_q.size(); f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, BIT_NS);
      rx_in = 1'b0;
      #(2 * BIT_NS);
      idle(2);
      check("t4_ferr",     32'(ferr_cnt - f0), 32'd1);
      check("t4_no_data",  32'(hs_q.size() - base), 32'd0);
      check("t4_valid",    32'(valid_out), 32'h0);
      send_frame(8'h81, 1'b1, BIT_NS);
      idle(1);
      check("t4_recover_count", 32'(hs_q.size() - base), 32'd1);
      check("t4_recover_byte",  32'(hs_q[base]), 32'h81);

      // 5: overrun with consumer stalled
      @(posedge clk_in); #1 ready_in = 1'b0;
      base = hs_q.size(); o0 = ovr_cnt;
      send_frame(8'h11, 1'b1, BIT_NS);
      send_frame(8'h22, 1'b1, BIT_NS);
      idle(1);
      check("t5_valid", 32'(valid_out), 32'h1);
      check("t5_data",  32'(data_out), 32'h11);
      check("t5_ovr",   32'(ovr_cnt - o0), 32'd1);
      @(posedge clk_in); #1 ready_in = 1'b1;
      @(posedge clk_in); #1;
      check("t5_valid_clr", 32'(valid_out), 32'h0);
      check("t5_hs_count",  32'(hs_q.size() - base), 32'd1);
      check("t5_hs_byte",   32'(hs_q[base]), 32'h11);

      // 6: mid-frame reset at nominal, fast and slow rates
      rates[0] = BIT_NS; rates[1] = FAST_NS; rates[2] = SLOW_NS;
      partial = 8'hF0;
      for (int r = 0; r < 3; r++) begin
         rate = rates[r];
         rx_in = 1'b0;
         #(rate);
         for (int i = 0; i < 4; i++) begin
            rx_in = partial[i];
            #(rate);
         end
         rx_in = partial[4];
         #(rate / 2);
         check("t6_busy_pre", 32'(busy_out), 32'h1);
         rst_in = 1'b0;
         rx_in  = 1'b1;
         #30;
         check_reset_outputs("t6_rst");
         rst_in = 1'b1;
         idle(2);
         base = hs_q.size();
         send_frame(8'h96, 1'b1, rate);
         idle(1);
         check("t6_count", 32'(hs_q.size() - base), 32'd1);
         check("t6_byte",  32'(hs_q[base]), 32'h96);
      end

      // Randomised frames within the baud tolerance, random idle gaps
      base = hs_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom);
         rate = int'($urandom_range(FAST_NS, SLOW_NS - 1));
         exp_q.push_back(rb);
         send_frame(rb, 1'b1, rate);
         rx_in = 1'b1;
         #(int'($urandom_range(0, 1)) * BIT_NS);
      end
      idle(2);
      check("rnd_count", 32'(hs_q.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
         check("rnd_byte", 32'(hs_q[base+i]), 32'(exp_q[i]));
      check("rnd_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("rnd_ovr",  32'(ovr_cnt - o0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
